wide_add_sequencer: RTL and testbench
=====================================

// Module: wide_add_sequencer
// PURPOSE
//  Multi-precision add/subtract sequencer placed directly upstream of the 16-bit
//  prefix adder. Accepts 16-bit operand limbs LS-first over a valid/ready stream.
//  Drives the adder's A/B/Cin, and registers its Sum/Cout as the carry into the next limb.
//  Emits one registered 16-bit result limb per accepted input limb, plus final
//  carry and signed overflow on the last limb.
// PARAMETERS
//  MAX_LIMBS  8                   max limbs per operation; longer ops are flagged
//  IDX_W      $clog2(MAX_LIMBS)   width of limb index
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      reset, asynchronous, active-high
//  in_valid   in   1      input limb valid
//  in_ready   out  1      input limb accepted when in_valid&in_ready
//  in_a       in   16     operand A limb
//  in_b       in   16     operand B limb
//  in_first   in   1      limb is LS limb of a new operation
//  in_last    in   1      limb is MS limb (first&last = single-limb op)
//  in_sub     in   1      1 = A-B; sampled on first limb only, held for the op
//  out_valid  out  1      result limb valid
//  out_ready  in   1      downstream accepts result limb
//  out_sum    out  16     result limb
//  out_idx    out  IDX_W  limb index within the op (0 = LS)
//  out_last   out  1      result limb is MS limb
//  out_carry  out  1      carry out of MS limb (valid with out_last; sub: 1 = no borrow)
//  out_ovf    out  1      signed overflow of full-width result (valid with out_last)
//  out_err    out  1      framing error on this limb (see below)
// BEHAVIOUR
//  - Reset: out_valid=0, all out_* data=0, carry_q=0, sub_q=0, idx=0, state=IDLE.
//    in_ready=1 during/after reset (combinational from out_valid).
//  - Handshake: in_ready = !out_valid | out_ready. Single output register, 1-cycle latency.
//    A limb accepted at edge N appears on out_* at N+1.
//  - out_* hold stable while out_valid & !out_ready. Full throughput (1 limb/clk) when out_ready=1.
//  - Adder drive: A=in_a; B=sub_eff ? ~in_b : in_b; Cin=start ? sub_eff : carry_q.
//    start = in_first | (state==IDLE); sub_eff = start ? in_sub : sub_q.
//  - On accept: out_sum<=Sum; carry_q<=Cout; out_idx<=start ? 0 : idx+1 (saturate at MAX_LIMBS-1).
//    If start: sub_q<=in_sub.
//  - On last limb: out_carry<=Cout; out_ovf<=(A[15]==B[15]) & (Sum[15]!=A[15]).
//    Otherwise out_carry=out_ovf=0.
//  - FSM: IDLE --accept & !in_last--> BUSY; BUSY --accept & in_last--> IDLE.
//    first&last in IDLE stays IDLE. No transition without accept.
//  - Framing errors: out_err=1 on the output limb, and the op continues.
//    - in_first while BUSY: previous op abandoned, new op starts.
//    - !in_first while IDLE: treated as start.
//    - Limb with out_idx saturating past MAX_LIMBS-1: err; index held.
//  - Simultaneous out_ready and accept: old result drains, new result loads same edge.
//  - Reset mid-operation: op discarded. The next limb must carry in_first, otherwise it is flagged as err.
//  - Width: all limb arithmetic is mod 2^16. Carry chain lives only in carry_q (1 bit).
// STRUCTURE
//  - Shared package: LIMB_W=16 constant; FSM state enum {IDLE,BUSY}.
//  - One sub-module: the existing 16-bit Sklansky prefix adder (module Sklanksy),
//    instantiated once combinationally between input mux and output register.
//  - Remaining logic is operand inversion mux, carry/sub/idx registers, 2-state FSM
//    and output register. No other sub-modules.
// TESTING
//  - 1-limb add: a=0xFFFF,b=0x0001,first=last=1,sub=0
//    -> sum=0x0000,carry=1,ovf=0,idx=0, one cycle later.
//  - 3-limb add: A=0x0000_FFFF_FFFF + B=0x0000_0000_0001 back-to-back
//    -> sums 0x0000,0x0000,0x0001; carry=0; idx 0,1,2; last on 3rd.
//  - 2-limb sub: A=0x0000_0000, B=0x0000_0001
//    -> sums 0xFFFF,0xFFFF; carry=0 (borrow); ovf=0.
//  - Signed ovf: 1-limb 0x7FFF+0x0001 -> sum=0x8000, ovf=1.
//    1-limb sub 0x8000-0x0001 -> sum=0x7FFF, ovf=1, carry=1.
//  - Backpressure: hold out_ready=0 for 3 cycles mid-op
//    -> in_ready=0, out_* stable, no limb lost or duplicated, carry chain intact.
//  - Framing/reset:
//    - in_first during BUSY -> err=1, idx=0, Cin from in_sub.
//    - rst pulse mid-op -> out_valid=0, next non-first limb err=1.
//    - 9th limb with MAX_LIMBS=8 -> err=1, idx=7.

Source files
------------

// File: rtl/wide_add_sequencer_pkg.sv
// Shared definitions for the multi-precision add/subtract sequencer.
// Limb width and sequencer FSM state encoding.
// Imported by the sequencer top and its prefix adder.
package wide_add_sequencer_pkg;

  localparam int LIMB_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/Sklanksy.sv
// 16-bit Sklansky parallel-prefix adder with carry-in and carry-out.
// Latency: purely combinational, zero cycles.
// Backpressure: none, no state and no handshake.
module Sklanksy
  import wide_add_sequencer_pkg::*;
(
  input  logic [LIMB_W-1:0] a,
  input  logic [LIMB_W-1:0] b,
  input  logic              cin,
  output logic [LIMB_W-1:0] sum,
  output logic              cout
);

  localparam int LVLS = $clog2(LIMB_W);

  // Prefix tree: at level l, every bit whose l-th index bit is set absorbs the
  // group ending just below its 2^l-aligned block. Cin is folded into bit 0's
  // generate, so the final group generate of bit i is the carry into bit i+1.
  function automatic logic [LIMB_W:0] prefix_add(input logic [LIMB_W-1:0] x,
                                                 input logic [LIMB_W-1:0] y,
                                                 input logic            ci);
    logic [LIMB_W-1:0] prop;
    logic [LIMB_W-1:0] g;
    logic [LIMB_W-1:0] p;
    logic [LIMB_W-1:0] g_nxt;
    logic [LIMB_W-1:0] p_nxt;
    prop = x ^ y;
    g    = x & y;
    g[0] = g[0] | (prop[0] & ci);
    p    = prop;
    for (int l = 0; l < LVLS; l++) begin
      g_nxt = g;
      p_nxt = p;
      for (int i = 0; i < LIMB_W; i++) begin
        if (((i >> l) & 1) != 0) begin
          int j;
          j = ((i >> l) << l) - 1;
          g_nxt[i] = g[i] | (p[i] & g[j]);
          p_nxt[i] = p[i] & p[j];
        end
      end
      g = g_nxt;
      p = p_nxt;
    end
    return {g[LIMB_W-1], prop ^ {g[LIMB_W-2:0], ci}};
  endfunction

  // Split the packed carry/sum result onto the ports.
  always_comb begin
    {cout, sum} = prefix_add(a, b, cin);
  end

endmodule

// File: rtl/wide_add_sequencer.sv
// Multi-precision add/subtract over 16-bit limbs, LS limb first, via one prefix adder.
// Latency: one cycle; a limb accepted at edge N is presented on out_* after edge N.
// Backpressure: in_ready = !out_valid | out_ready; outputs hold while stalled.
module wide_add_sequencer
  import wide_add_sequencer_pkg::*;
#(
  parameter int MAX_LIMBS = 8,
  parameter int IDX_W     = $clog2(MAX_LIMBS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LIMB_W-1:0] in_a,
  input  logic [LIMB_W-1:0] in_b,
  input  logic              in_first,
  input  logic              in_last,
  input  logic              in_sub,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LIMB_W-1:0] out_sum,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_last,
  output logic              out_carry,
  output logic              out_ovf,
  output logic              out_err
);

  localparam int MSB = LIMB_W - 1;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(MAX_LIMBS - 1);

  state_t            state;
  logic              carry_q;
  logic              sub_q;
  logic              accept;
  logic              start;
  logic              sub_eff;
  logic              add_cin;
  logic              add_cout;
  logic              sat;
  logic              frame_err;
  logic [LIMB_W-1:0] add_b;
  logic [LIMB_W-1:0] add_sum;

  assign in_ready = !out_valid | out_ready;
  assign accept   = in_valid & in_ready;

  // A limb opens a new operation when flagged first, or when no operation is
  // open (including right after reset, where a missing first flag is an error).
  assign start   = in_first | (state == IDLE);
  assign sub_eff = start ? in_sub : sub_q;
  assign add_b   = sub_eff ? ~in_b : in_b;
  assign add_cin = start ? sub_eff : carry_q;

  // Index saturates at the last legal slot; further limbs reuse it and are flagged.
  assign sat       = !start && (out_idx == IDX_MAX);
  assign frame_err = (in_first & (state == BUSY)) | (!in_first & (state == IDLE)) | sat;

  Sklanksy u_adder (
    .a    (in_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Output register, carry/sub/index chain and the IDLE/BUSY operation FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      carry_q   <= 1'b0;
      sub_q     <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      out_carry <= 1'b0;
      out_ovf   <= 1'b0;
      out_err   <= 1'b0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (accept) begin
        out_sum   <= add_sum;
        carry_q   <= add_cout;
        out_idx   <= start ? '0 : (sat ? out_idx : out_idx + IDX_W'(1));
        out_last  <= in_last;
        out_carry <= in_last & add_cout;
        out_ovf   <= in_last & (in_a[MSB] == add_b[MSB]) & (add_sum[MSB] != in_a[MSB]);
        out_err   <= frame_err;
        state     <= in_last ? IDLE : BUSY;
        if (start) begin
          sub_q <= in_sub;
        end
      end
    end
  end

endmodule

// File: tb/tb_wide_add_sequencer.sv
module tb_wide_add_sequencer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_first;
  logic        in_last;
  logic        in_sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic [2:0]  out_idx;
  logic        out_last;
  logic        out_carry;
  logic        out_ovf;
  logic        out_err;

  int tests_run;
  int tests_failed;

  // {valid, sum, idx, last, carry, ovf, err}
  logic [23:0] obs;
  assign obs = {out_valid, out_sum, out_idx, out_last, out_carry, out_ovf, out_err};

  wide_add_sequencer #(.MAX_LIMBS(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_first  (in_first),
    .in_last   (in_last),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .out_carry (out_carry),
    .out_ovf   (out_ovf),
    .out_err   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one limb for one clock (caller keeps out_ready=1), sample point is #1 after the edge.
  task automatic drive_limb(input logic [15:0] a, input logic [15:0] b,
                            input logic first, input logic last, input logic sub);
    in_a     = a;
    in_b     = b;
    in_first = first;
    in_last  = last;
    in_sub   = sub;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset;
    logic [23:0] exp;
    rst = 1'b1;
    #1;
    exp = 24'h0;
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL reset_outputs got %h exp %h", obs, exp);
    end
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_in_ready got %b exp 1", in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_add1;
    logic [23:0] exp;
    drive_limb(16'hFFFF, 16'h0001, 1'b1, 1'b1, 1'b0);
    exp = {1'b1, 16'h0000, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL add1 got %h exp %h", obs, exp);
    end
  endtask

  task automatic test_add3;
    logic [23:0] exp [3];
    logic [15:0] a [3];
    logic [15:0] b [3];
    a = '{16'hFFFF, 16'hFFFF, 16'h0000};
    b = '{16'h0001, 16'h0000, 16'h0000};
    exp[0] = {1'b1, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    exp[1] = {1'b1, 16'h0000, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    exp[2] = {1'b1, 16'h0001, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int k = 0; k < 3; k++) begin
      drive_limb(a[k], b[k], k == 0, k == 2, 1'b0);
      tests_run++;
      if (obs !== exp[k]) begin
        tests_failed++;
        $display("FAIL add3_limb%0d got %h exp %h", k, obs, exp[k]);
      end
    end
  endtask

  task automatic test_sub2;
    logic [23:0] exp;
    drive_limb(16'h0000, 16'h0001, 1'b1, 1'b0, 1'b1);
    exp = {1'b1, 16'hFFFF, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL sub2_limb0 got %h exp %h", obs, exp);
    end
    // sub flag is only sampled on the first limb; drive 0 here to prove it is held
    drive_limb(16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
    exp = {1'b1, 16'hFFFF, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0};
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL sub2_limb1 got %h exp %h", obs, exp);
    end
  endtask

  task automatic test_ovf;
    logic [23:0] exp;
    drive_limb(16'h7FFF, 16'h0001, 1'b1, 1'b1, 1'b0);
    exp = {1'b1, 16'h8000, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0};
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL ovf_add got %h exp %h", obs, exp);
    end
    drive_limb(16'h8000, 16'h0001, 1'b1, 1'b1, 1'b1);
    exp = {1'b1, 16'h7FFF, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0};
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL ovf_sub got %h exp %h", obs, exp);
    end
  endtask

  task automatic test_backpressure;
    logic [23:0] exp0;
    logic [23:0] exp;
    drive_limb(16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b0);
    exp0 = {1'b1, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    tests_run++;
    if (obs !== exp0) begin
      tests_failed++;
      $display("FAIL bp_limb0 got %h exp %h", obs, exp0);
    end
    out_ready = 1'b0;
    in_a      = 16'hFFFF;
    in_b      = 16'h0000;
    in_first  = 1'b0;
    in_last   = 1'b0;
    in_sub    = 1'b0;
    in_valid  = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      tests_run++;
      if (in_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL bp_in_ready_cyc%0d got %b exp 0", c, in_ready);
      end
      tests_run++;
      if (obs !== exp0) begin
        tests_failed++;
        $display("FAIL bp_hold_cyc%0d got %h exp %h", c, obs, exp0);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    exp = {1'b1, 16'h0000, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL bp_limb1 got %h exp %h", obs, exp);
    end
    drive_limb(16'h0001, 16'h0000, 1'b0, 1'b1, 1'b0);
    exp = {1'b1, 16'h0002, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0};
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL bp_limb2 got %h exp %h", obs, exp);
    end
  endtask

  task automatic test_first_busy;
    logic [23:0] exp;
    drive_limb(16'h0001, 16'h0001, 1'b1, 1'b0, 1'b0);
    exp = {1'b1, 16'h0002, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL fb_limb0 got %h exp %h", obs, exp);
    end
    // 5 - 3 restarted mid-op: 0x0005 + 0xFFFC + 1 = 0x0002, carry 1
    drive_limb(16'h0005, 16'h0003, 1'b1, 1'b1, 1'b1);
    exp = {1'b1, 16'h0002, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1};
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL fb_restart got %h exp %h", obs, exp);
    end
  endtask

  task automatic test_rst_mid;
    logic [23:0] exp;
    drive_limb(16'h0001, 16'h0001, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    #2;
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_valid got %b exp 0", out_valid);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    drive_limb(16'h0003, 16'h0004, 1'b0, 1'b1, 1'b0);
    exp = {1'b1, 16'h0007, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1};
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL rst_mid_nofirst got %h exp %h", obs, exp);
    end
  endtask

  task automatic test_saturate;
    logic [23:0] exp;
    logic [2:0]  eidx;
    for (int k = 0; k < 9; k++) begin
      drive_limb(16'h0000, 16'h0000, k == 0, k == 8, 1'b0);
      eidx = (k > 7) ? 3'd7 : 3'(k);
      exp  = {1'b1, 16'h0000, eidx, k == 8, 1'b0, 1'b0, k == 8};
      tests_run++;
      if (obs !== exp) begin
        tests_failed++;
        $display("FAIL sat_limb%0d got %h exp %h", k, obs, exp);
      end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    in_valid     = 1'b0;
    in_a         = 16'h0;
    in_b         = 16'h0;
    in_first     = 1'b0;
    in_last      = 1'b0;
    in_sub       = 1'b0;
    out_ready    = 1'b1;

    test_reset();
    test_add1();
    test_add3();
    test_sub2();
    test_ovf();
    test_backpressure();
    test_first_busy();
    test_rst_mid();
    test_saturate();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
